pwm_output_sequencer: RTL and testbench

//  Soft-start/soft-stop gate between main's PWM outputs and the XDCR_OUT pins.

---
 rtl/pwm_output_sequencer.sv | 119 +++++++++++
 tb/tb_pwm_output_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_sequencer.sv
// Soft-start/stop gate for transducer PWM: groups enabled/disabled one step at a time, force-off kills all and latches a fault.
// Latency: PWM_OUT is PWM_IN registered one cycle, gated by the registered enabled-group count.
// Backpressure: none; free-running per-cycle path, ramp pacing set by STEP_CYCLES.
module pwm_output_sequencer #(
    parameter int DEPTH       = 249,
    parameter int GROUP_SIZE  = 16,
    parameter int STEP_CYCLES = 10240,
    localparam int NG = (DEPTH + GROUP_SIZE - 1) / GROUP_SIZE,
    localparam int NW = $clog2(NG + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN_REQ,
    input  logic          FORCE_OFF,
    input  logic          PWM_IN  [DEPTH],
    output logic          PWM_OUT [DEPTH],
    output logic [NW-1:0] EN_GROUPS,
    output logic [1:0]    STATE,
    output logic          FAULT
);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    localparam int            TW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [NW-1:0] N_MAX  = NW'(NG);
    localparam logic [NW-1:0] N_ONE  = NW'(1);

    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fault_q, fault_d;
    logic          step;

    assign step = (timer_q == T_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_OFF;
            n_q     <= '0;
            timer_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            timer_q <= timer_d;
            fault_q <= fault_d;
        end
    end

    // Timer defaults to 0, so any state change or step boundary restarts the interval.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        timer_d = '0;
        fault_d = fault_q;
        if (FORCE_OFF) begin
            state_d = S_OFF;
            n_d     = '0;
            fault_d = 1'b1;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    if (fault_q) begin
                        if (!EN_REQ) fault_d = 1'b0;
                    end else if (EN_REQ) begin
                        n_d     = N_ONE;
                        state_d = (NG == 1) ? S_ON : S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (!EN_REQ) begin
                        state_d = S_RAMP_DOWN;
                    end else if (step) begin
                        if (n_q < N_MAX) n_d = n_q + N_ONE;
                        if (n_q >= N_MAX - N_ONE) state_d = S_ON;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_ON: begin
                    if (!EN_REQ) state_d = S_RAMP_DOWN;
                end
                S_RAMP_DOWN: begin
                    if (EN_REQ) begin
                        state_d = S_RAMP_UP;
                    end else if (step) begin
                        if (n_q != '0) n_d = n_q - N_ONE;
                        if (n_q <= N_ONE) state_d = S_OFF;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        STATE     = state_q;
        EN_GROUPS = n_q;
        FAULT     = fault_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) PWM_OUT[i] <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                PWM_OUT[i] <= PWM_IN[i] & (NW'(i / GROUP_SIZE) < n_q);
        end
    end

endmodule

// File: tb/tb_pwm_output_sequencer.sv
// Directed bench for pwm_output_sequencer: 16-group instance plus a single-group (NG=1) instance.
module tb_pwm_output_sequencer;

    localparam int DEPTH = 249;

    logic             CLK = 1'b0;
    logic             RESET, EN_REQ, FORCE_OFF;
    logic             PWM_IN   [DEPTH];
    logic             PWM_OUT  [DEPTH];
    logic             PWM_OUT1 [DEPTH];
    logic [4:0]       en_groups;
    logic [0:0]       en_groups1;
    logic [1:0]       state, state1;
    logic             fault, fault1;
    logic [DEPTH-1:0] pwm_vec, pwm_vec1, exp_vec;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    pwm_output_sequencer #(.DEPTH(DEPTH), .GROUP_SIZE(16), .STEP_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .EN_REQ(EN_REQ), .FORCE_OFF(FORCE_OFF),
        .PWM_IN(PWM_IN), .PWM_OUT(PWM_OUT), .EN_GROUPS(en_groups),
        .STATE(state), .FAULT(fault)
    );

    pwm_output_sequencer #(.DEPTH(DEPTH), .GROUP_SIZE(256), .STEP_CYCLES(4)) dut1 (
        .CLK(CLK), .RESET(RESET), .EN_REQ(EN_REQ), .FORCE_OFF(FORCE_OFF),
        .PWM_IN(PWM_IN), .PWM_OUT(PWM_OUT1), .EN_GROUPS(en_groups1),
        .STATE(state1), .FAULT(fault1)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pwm_vec[i]  = PWM_OUT[i];
            pwm_vec1[i] = PWM_OUT1[i];
        end
    end

    function automatic logic [DEPTH-1:0] exp_mask(input int n);
        logic [DEPTH-1:0] m;
        for (int i = 0; i < DEPTH; i++) m[i] = ((i / 16) < n);
        return m;
    endfunction

    // Expected N, c cycles after EN_REQ rises from OFF (ramp up) or falls in ON (ramp down).
    function automatic int n_up(input int c);
        if (c < 1) return 0;
        return (1 + (c - 1) / 4 > 16) ? 16 : 1 + (c - 1) / 4;
    endfunction

    function automatic int n_down(input int c);
        if (c < 1) return 16;
        return (16 - (c - 1) / 4 < 0) ? 0 : 16 - (c - 1) / 4;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_pwm_all(input logic v);
        for (int i = 0; i < DEPTH; i++) PWM_IN[i] = v;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        EN_REQ = 1'b0;
        FORCE_OFF = 1'b0;
        set_pwm_all(1'b1);
        #2;
        RESET = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        EN_REQ = 1'b0;
        FORCE_OFF = 1'b0;
        set_pwm_all(1'b1);
        #2;
        n_checks++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
        n_checks++; if (en_groups !== 5'd0) $display("FAIL reset_n got %0d want 0", en_groups); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else n_pass++;
        n_checks++; if (pwm_vec !== '0) $display("FAIL reset_pwm got %h want 0", pwm_vec); else n_pass++;
        n_checks++; if (state1 !== 2'd0) $display("FAIL reset_state_ng1 got %0d want 0", state1); else n_pass++;
        #1;
        RESET = 1'b0;
        tick(2);
        n_checks++; if (state !== 2'd0 || en_groups !== 5'd0) $display("FAIL idle_off got state %0d n %0d want 0 0", state, en_groups); else n_pass++;
    endtask

    task automatic test_ramp_up();
        do_reset();
        EN_REQ = 1'b1;
        for (int c = 1; c <= 62; c++) begin
            tick(1);
            n_checks++;
            if (en_groups !== 5'(n_up(c))) $display("FAIL ramp_up_n c=%0d got %0d want %0d", c, en_groups, n_up(c)); else n_pass++;
            n_checks++;
            if (state !== ((c >= 61) ? 2'd2 : 2'd1)) $display("FAIL ramp_up_state c=%0d got %0d", c, state); else n_pass++;
            exp_vec = exp_mask(n_up(c - 1));
            n_checks++;
            if (pwm_vec !== exp_vec) $display("FAIL ramp_up_pwm c=%0d got %h want %h", c, pwm_vec, exp_vec); else n_pass++;
        end
        tick(5);
        n_checks++; if (state !== 2'd2 || en_groups !== 5'd16) $display("FAIL on_hold got state %0d n %0d want 2 16", state, en_groups); else n_pass++;
    endtask

    task automatic test_pwm_pattern();
        for (int i = 0; i < DEPTH; i++) begin
            PWM_IN[i] = ((i % 3) == 0);
            exp_vec[i] = ((i % 3) == 0);
        end
        tick(1);
        n_checks++; if (pwm_vec !== exp_vec) $display("FAIL pwm_pattern got %h want %h", pwm_vec, exp_vec); else n_pass++;
        set_pwm_all(1'b1);
        tick(1);
        exp_vec = exp_mask(16);
        n_checks++; if (pwm_vec !== exp_vec) $display("FAIL pwm_restore got %h want %h", pwm_vec, exp_vec); else n_pass++;
    endtask

    task automatic test_ramp_down();
        EN_REQ = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            tick(1);
            n_checks++;
            if (en_groups !== 5'(n_down(c))) $display("FAIL ramp_down_n c=%0d got %0d want %0d", c, en_groups, n_down(c)); else n_pass++;
            n_checks++;
            if (state !== ((c >= 65) ? 2'd0 : 2'd3)) $display("FAIL ramp_down_state c=%0d got %0d", c, state); else n_pass++;
            exp_vec = exp_mask(n_down(c - 1));
            n_checks++;
            if (pwm_vec !== exp_vec) $display("FAIL ramp_down_pwm c=%0d got %h want %h", c, pwm_vec, exp_vec); else n_pass++;
        end
    endtask

    task automatic test_reversal();
        int exp_n;
        do_reset();
        EN_REQ = 1'b1;
        tick(17);
        n_checks++; if (en_groups !== 5'd5 || state !== 2'd1) $display("FAIL rev_start got n %0d state %0d want 5 1", en_groups, state); else n_pass++;
        EN_REQ = 1'b0;
        for (int d = 1; d <= 9; d++) begin
            tick(1);
            exp_n = (d < 5) ? 5 : (d < 9) ? 4 : 3;
            n_checks++;
            if (en_groups !== 5'(exp_n) || state !== 2'd3) $display("FAIL rev_down d=%0d got n %0d state %0d want %0d 3", d, en_groups, state, exp_n); else n_pass++;
        end
        EN_REQ = 1'b1;
        for (int d = 10; d <= 14; d++) begin
            tick(1);
            exp_n = (d < 14) ? 3 : 4;
            n_checks++;
            if (en_groups !== 5'(exp_n) || state !== 2'd1) $display("FAIL rev_up d=%0d got n %0d state %0d want %0d 1", d, en_groups, state, exp_n); else n_pass++;
        end
        EN_REQ = 1'b0;
        tick(16);
        n_checks++; if (en_groups !== 5'd1 || state !== 2'd3) $display("FAIL rev_last got n %0d state %0d want 1 3", en_groups, state); else n_pass++;
        tick(1);
        n_checks++; if (en_groups !== 5'd0 || state !== 2'd0) $display("FAIL rev_off got n %0d state %0d want 0 0", en_groups, state); else n_pass++;
        tick(1);
        n_checks++; if (pwm_vec !== '0) $display("FAIL rev_pwm got %h want 0", pwm_vec); else n_pass++;
    endtask

    task automatic test_force_off();
        do_reset();
        EN_REQ = 1'b1;
        tick(61);
        n_checks++; if (state !== 2'd2) $display("FAIL fo_on got %0d want 2", state); else n_pass++;
        FORCE_OFF = 1'b1;
        tick(1);
        FORCE_OFF = 1'b0;
        n_checks++; if (en_groups !== 5'd0 || state !== 2'd0) $display("FAIL fo_kill got n %0d state %0d want 0 0", en_groups, state); else n_pass++;
        n_checks++; if (fault !== 1'b1) $display("FAIL fo_fault got %b want 1", fault); else n_pass++;
        tick(1);
        n_checks++; if (pwm_vec !== '0) $display("FAIL fo_pwm got %h want 0", pwm_vec); else n_pass++;
        tick(5);
        n_checks++; if (state !== 2'd0 || fault !== 1'b1 || en_groups !== 5'd0) $display("FAIL fo_stuck_en got state %0d fault %b n %0d want 0 1 0", state, fault, en_groups); else n_pass++;
        EN_REQ = 1'b0;
        FORCE_OFF = 1'b1;
        tick(2);
        n_checks++; if (fault !== 1'b1) $display("FAIL fo_held got %b want 1", fault); else n_pass++;
        FORCE_OFF = 1'b0;
        tick(1);
        n_checks++; if (fault !== 1'b0 || state !== 2'd0) $display("FAIL fo_clear got fault %b state %0d want 0 0", fault, state); else n_pass++;
        EN_REQ = 1'b1;
        tick(1);
        n_checks++; if (en_groups !== 5'd1 || state !== 2'd1) $display("FAIL fo_restart got n %0d state %0d want 1 1", en_groups, state); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        EN_REQ = 1'b1;
        tick(25);
        n_checks++; if (en_groups !== 5'd7) $display("FAIL ar_n7 got %0d want 7", en_groups); else n_pass++;
        tick(1);
        exp_vec = exp_mask(7);
        n_checks++; if (pwm_vec !== exp_vec) $display("FAIL ar_pwm7 got %h want %h", pwm_vec, exp_vec); else n_pass++;
        #2;
        RESET = 1'b1;
        #1;
        n_checks++; if (pwm_vec !== '0) $display("FAIL ar_pwm_async got %h want 0", pwm_vec); else n_pass++;
        n_checks++; if (en_groups !== 5'd0 || state !== 2'd0) $display("FAIL ar_regs got n %0d state %0d want 0 0", en_groups, state); else n_pass++;
        RESET = 1'b0;
        tick(1);
        n_checks++; if (en_groups !== 5'd1 || state !== 2'd1) $display("FAIL ar_restart got n %0d state %0d want 1 1", en_groups, state); else n_pass++;
    endtask

    task automatic test_ng1();
        do_reset();
        EN_REQ = 1'b1;
        tick(1);
        n_checks++; if (state1 !== 2'd2 || en_groups1 !== 1'b1) $display("FAIL ng1_on got state %0d n %0d want 2 1", state1, en_groups1); else n_pass++;
        tick(1);
        n_checks++; if (pwm_vec1 !== {DEPTH{1'b1}}) $display("FAIL ng1_pwm got %h want all ones", pwm_vec1); else n_pass++;
        EN_REQ = 1'b0;
        tick(1);
        n_checks++; if (state1 !== 2'd3 || en_groups1 !== 1'b1) $display("FAIL ng1_rd got state %0d n %0d want 3 1", state1, en_groups1); else n_pass++;
        tick(3);
        n_checks++; if (state1 !== 2'd3) $display("FAIL ng1_rd_hold got %0d want 3", state1); else n_pass++;
        tick(1);
        n_checks++; if (state1 !== 2'd0 || en_groups1 !== 1'b0) $display("FAIL ng1_off got state %0d n %0d want 0 0", state1, en_groups1); else n_pass++;
        tick(1);
        n_checks++; if (pwm_vec1 !== '0) $display("FAIL ng1_pwm_off got %h want 0", pwm_vec1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_pwm_pattern();
        test_ramp_down();
        test_reversal();
        test_force_off();
        test_async_reset();
        test_ng1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
